// File: rtl/asteroids_pkg.sv
// rtl/asteroids_pkg.sv - shared slot-table layout and draw sequencer state encoding
package asteroids_pkg;

    // Slot word: {active, sprite_sel[2:0], y[9:0], x[9:0]}
    localparam int SLOT_W          = 24;
    localparam int COORD_W         = 10;
    localparam int SEL_W           = 3;

    localparam int SLOT_ACTIVE_BIT = 23;
    localparam int SLOT_SEL_MSB    = 22;
    localparam int SLOT_SEL_LSB    = 20;
    localparam int SLOT_Y_MSB      = 19;
    localparam int SLOT_Y_LSB      = 10;
    localparam int SLOT_X_MSB      = 9;
    localparam int SLOT_X_LSB      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_CHECK,
        ST_PLOT,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_DONE
    } draw_state_e;

endpackage

// File: rtl/draw_watchdog.sv
// rtl/draw_watchdog.sv - load/enable cycle counter with terminal-count flag
//   clk, reset : clock, synchronous active-high reset
//   load       : clear the count to zero
//   enable     : advance the count by one (holds at terminal count)
//   tc         : count has reached TIMEOUT-1
module draw_watchdog #(
    parameter int TIMEOUT = 2048,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    // Saturate at terminal count so a stray enable can never wrap to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/asteroid_draw_sequencer.sv
// rtl/asteroid_draw_sequencer.sv - per-frame asteroid slot table walker issuing sprite draws
//   clk, reset          : clock, synchronous active-high reset
//   frame_start         : pulse, begin a table walk (merged into pending while busy)
//   slot_addr/slot_data : slot table read port, data valid one cycle after address
//   x_pos/y_pos/sprite_sel, plot, draw_done : draw request handshake to draw_asteroid
//   busy, frame_done, timeout_err           : status to the frame controller
module asteroid_draw_sequencer
    import asteroids_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_AW   = 3,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int TIMEOUT   = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    output logic [SLOT_AW-1:0] slot_addr,
    input  logic [23:0]        slot_data,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic [2:0]         sprite_sel,
    output logic               plot,
    input  logic               draw_done,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_err
);

    localparam logic [SLOT_AW-1:0] LAST_SLOT  = SLOT_AW'(NUM_SLOTS - 1);
    localparam logic [COORD_W-1:0] SCREEN_W_C = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);

    draw_state_e        state_q, state_d;
    logic [SLOT_AW-1:0] slot_addr_q, slot_addr_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic               pending_q, pending_d;

    logic               wd_load;
    logic               wd_en;
    logic               wd_tc;

    logic               slot_active;
    logic [SEL_W-1:0]   slot_sel;
    logic [COORD_W-1:0] slot_y;
    logic [COORD_W-1:0] slot_x;

    assign slot_active = slot_q[SLOT_ACTIVE_BIT];
    assign slot_sel    = slot_q[SLOT_SEL_MSB:SLOT_SEL_LSB];
    assign slot_y      = slot_q[SLOT_Y_MSB:SLOT_Y_LSB];
    assign slot_x      = slot_q[SLOT_X_MSB:SLOT_X_LSB];

    draw_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (wd_load),
        .enable (wd_en),
        .tc     (wd_tc)
    );

    always_comb begin
        state_d      = state_q;
        slot_addr_d  = slot_addr_q;
        slot_d       = slot_q;
        x_d          = x_q;
        y_d          = y_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        pending_d    = pending_q;
        wd_load      = 1'b0;
        wd_en        = 1'b0;

        // Any start request outside IDLE (including the DONE cycle) is
        // remembered as a single bit and replayed once the walk finishes.
        if (frame_start && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start || pending_q) begin
                    state_d     = ST_FETCH;
                    slot_addr_d = '0;
                    busy_d      = 1'b1;
                    pending_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                slot_d  = slot_data;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!slot_active || (slot_x >= SCREEN_W_C) || (slot_y >= SCREEN_H_C)) begin
                    state_d = ST_NEXT;
                end else begin
                    x_d     = slot_x;
                    y_d     = slot_y;
                    sel_d   = slot_sel;
                    state_d = ST_PLOT;
                end
            end
            ST_PLOT: begin
                wd_load = 1'b1;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                wd_en = 1'b1;
                // A completion arriving on the terminal cycle wins over the abort.
                if (draw_done) begin
                    state_d = ST_NEXT;
                end else if (wd_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (slot_addr_q == LAST_SLOT) begin
                    state_d = ST_DONE;
                end else begin
                    slot_addr_d = slot_addr_q + 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            slot_addr_q  <= '0;
            slot_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_addr_q  <= slot_addr_d;
            slot_q       <= slot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            pending_q    <= pending_d;
        end
    end

    assign slot_addr   = slot_addr_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign sprite_sel  = sel_q;
    assign plot        = (state_q == ST_PLOT);
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_asteroid_draw_sequencer.sv
// tb/tb_asteroid_draw_sequencer.sv - directed vector bench for asteroid_draw_sequencer
module tb_asteroid_draw_sequencer;

    localparam int NUM_SLOTS = 8;
    localparam int NVEC      = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [2:0]  slot_addr;
    logic [23:0] slot_data;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [2:0]  sprite_sel;
    logic        plot;
    logic        draw_done;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    logic [23:0] ram [NUM_SLOTS];

    int tests = 0;
    int fails = 0;

    asteroid_draw_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .slot_addr   (slot_addr),
        .slot_data   (slot_data),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .sprite_sel  (sprite_sel),
        .plot        (plot),
        .draw_done   (draw_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) slot_data <= ram[slot_addr];

    typedef struct {
        logic [NUM_SLOTS*24-1:0] tbl;
        int                      lat;
        int                      exp_plots;
        int                      exp_cycles;
        int                      exp_gap;
        logic [9:0]              ex;
        logic [9:0]              ey;
        logic [2:0]              esel;
        logic                    eerr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [23:0] mk(input logic act, input logic [2:0] sel,
                                       input logic [9:0] y, input logic [9:0] x);
        return {act, sel, y, x};
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_ram(input logic [NUM_SLOTS*24-1:0] tbl);
        for (int i = 0; i < NUM_SLOTS; i++) ram[i] = tbl[i*24 +: 24];
    endtask

    task automatic pending_run(input int pa, input int pb, input int pc, input string tag);
        int fd1 = -1;
        int fd2 = -1;
        int nfd = 0;
        int extra = 0;
        logic busy35 = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        for (int cyc = 1; cyc <= 110; cyc++) begin
            @(negedge clk);
            frame_start = (cyc == pa) || (cyc == pb) || (cyc == pc);
            if (frame_done) begin
                nfd++;
                if (nfd == 1) fd1 = cyc;
                else if (nfd == 2) fd2 = cyc;
            end
            if (cyc == 35) busy35 = busy;
            if (cyc > 68 && busy) extra++;
        end
        frame_start = 1'b0;
        check({tag, " first frame_done cycle"}, fd1, 34);
        check({tag, " busy at restart"}, busy35, 1);
        check({tag, " second frame_done cycle"}, fd2, 68);
        check({tag, " frame_done count"}, nfd, 2);
        check({tag, " busy after second walk"}, extra, 0);
    endtask

    initial begin
        int nplots, fd_cyc, busy_bad, held_bad, gap_bad, last_plot, plot_seen, ign;
        logic waiting;
        logic [9:0] px, py;
        logic [2:0] psel;
        logic fd_busy;
        logic [NUM_SLOTS*24-1:0] t;

        // all inactive
        vecs[0] = '{tbl: '0, lat: -1, exp_plots: 0, exp_cycles: 34, exp_gap: 0,
                    ex: 10'd0, ey: 10'd0, esel: 3'd0, eerr: 1'b0};
        // single draw in slot 2, done 40 cycles after plot
        t = '0;
        t[2*24 +: 24] = mk(1'b1, 3'd5, 10'd100, 10'd200);
        vecs[1] = '{tbl: t, lat: 40, exp_plots: 1, exp_cycles: 75, exp_gap: 0,
                    ex: 10'd200, ey: 10'd100, esel: 3'd5, eerr: 1'b0};
        // off-screen active slots are skipped
        t = '0;
        t[0*24 +: 24] = mk(1'b1, 3'd1, 10'd10, 10'd640);
        t[1*24 +: 24] = mk(1'b1, 3'd2, 10'd480, 10'd5);
        vecs[2] = '{tbl: t, lat: -1, exp_plots: 0, exp_cycles: 34, exp_gap: 0,
                    ex: 10'd0, ey: 10'd0, esel: 3'd0, eerr: 1'b0};
        // last slot at the on-screen edge, draw_done right after plot
        t = '0;
        t[7*24 +: 24] = mk(1'b1, 3'd7, 10'd479, 10'd639);
        vecs[3] = '{tbl: t, lat: 1, exp_plots: 1, exp_cycles: 36, exp_gap: 0,
                    ex: 10'd639, ey: 10'd479, esel: 3'd7, eerr: 1'b0};
        // two draws, inactive on-screen slot between them
        t = '0;
        t[0*24 +: 24] = mk(1'b1, 3'd2, 10'd0, 10'd0);
        t[3*24 +: 24] = mk(1'b0, 3'd3, 10'd50, 10'd50);
        t[5*24 +: 24] = mk(1'b1, 3'd4, 10'd20, 10'd30);
        vecs[4] = '{tbl: t, lat: 3, exp_plots: 2, exp_cycles: 42, exp_gap: 24,
                    ex: 10'd30, ey: 10'd20, esel: 3'd4, eerr: 1'b0};
        // all active, draw_done never comes: every draw aborted by watchdog
        t = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            t[i*24 +: 24] = mk(1'b1, 3'(i), 10'(i*10), 10'(i*20));
        vecs[5] = '{tbl: t, lat: -1, exp_plots: 8, exp_cycles: 16426, exp_gap: 2053,
                    ex: 10'd140, ey: 10'd70, esel: 3'd7, eerr: 1'b1};

        reset = 1'b1;
        frame_start = 1'b0;
        draw_done = 1'b0;
        load_ram('0);
        repeat (3) @(negedge clk);
        check("reset slot_addr", slot_addr, 0);
        check("reset x_pos", x_pos, 0);
        check("reset y_pos", y_pos, 0);
        check("reset sprite_sel", sprite_sel, 0);
        check("reset plot", plot, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset timeout_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            load_ram(vecs[v].tbl);
            @(negedge clk);
            frame_start = 1'b1;
            nplots = 0; fd_cyc = -1; busy_bad = 0; held_bad = 0; gap_bad = 0;
            last_plot = -1; waiting = 1'b0; px = '0; py = '0; psel = '0; fd_busy = 1'b1;
            for (int cyc = 1; cyc <= vecs[v].exp_cycles + 100; cyc++) begin
                @(negedge clk);
                frame_start = 1'b0;
                draw_done = 1'b0;
                if (frame_done) begin
                    fd_cyc = cyc;
                    fd_busy = busy;
                    break;
                end
                if (!busy) busy_bad++;
                if (plot) begin
                    if (nplots > 0 && vecs[v].exp_gap > 0 && (cyc - last_plot) != vecs[v].exp_gap)
                        gap_bad++;
                    nplots++;
                    last_plot = cyc;
                    px = x_pos; py = y_pos; psel = sprite_sel;
                    waiting = (vecs[v].lat >= 0);
                end
                if (waiting) begin
                    if (x_pos !== px || y_pos !== py || sprite_sel !== psel) held_bad++;
                    if (cyc == last_plot + vecs[v].lat) begin
                        draw_done = 1'b1;
                        waiting = 1'b0;
                    end
                end
            end
            draw_done = 1'b0;
            check($sformatf("v%0d frame_done cycle", v), fd_cyc, vecs[v].exp_cycles);
            check($sformatf("v%0d plot count", v), nplots, vecs[v].exp_plots);
            check($sformatf("v%0d busy drop", v), busy_bad, 0);
            check($sformatf("v%0d busy at frame_done", v), fd_busy, 0);
            check($sformatf("v%0d coords held", v), held_bad, 0);
            check($sformatf("v%0d plot spacing", v), gap_bad, 0);
            check($sformatf("v%0d timeout_err", v), timeout_err, vecs[v].eerr);
            if (vecs[v].exp_plots > 0) begin
                check($sformatf("v%0d x_pos", v), px, vecs[v].ex);
                check($sformatf("v%0d y_pos", v), py, vecs[v].ey);
                check($sformatf("v%0d sprite_sel", v), psel, vecs[v].esel);
            end
        end

        load_ram('0);
        pending_run(5, 10, 20, "pending x3");
        pending_run(33, -1, -1, "pending in DONE");

        // reset while waiting on a draw
        t = '0;
        t[0*24 +: 24] = mk(1'b1, 3'd3, 10'd9, 10'd7);
        load_ram(t);
        @(negedge clk);
        frame_start = 1'b1;
        plot_seen = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (plot) plot_seen = cyc;
        end
        check("rst plot cycle", plot_seen, 4);
        check("rst sticky err before", timeout_err, 1);
        check("rst x_pos before", x_pos, 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst plot", plot, 0);
        check("rst busy", busy, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst slot_addr", slot_addr, 0);
        check("rst x_pos", x_pos, 0);
        ign = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            draw_done = (cyc == 2);
            @(negedge clk);
            if (plot || busy || frame_done || timeout_err) ign++;
        end
        draw_done = 1'b0;
        check("rst late draw_done ignored", ign, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
